// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_tx_param transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with combinational read of the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_FULL);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a word when one leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, valid/ready word input, LSB-first serial output.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the serialiser.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int CNT_MAX      = CLKS_PER_BIT - 1;
    localparam int IDX_MAX      = DATA_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_MAX[CNT_W-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_MAX[IDX_W-1:0];
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam parity_e          PAR_MODE  = parity_e'(PARITY);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_param: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_tx_param: FIFO_DEPTH must be a power of two, >= 2");
    end

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;
    logic                 src_valid;
    logic [DATA_BITS-1:0] src_data;
    logic                 src_take;

    // Handshake: a word transfers on the rising edge where data_valid && data_ready;
    // while data_ready is low the source must hold data_in and data_valid unchanged.
`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_BITS)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (data_valid && data_ready),
        .push_data(data_in),
        .pop      (src_take),
        .pop_data (src_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign data_ready = !fifo_full;
    assign src_valid  = !fifo_empty;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
`else
    assign data_ready = (state_q == S_IDLE) && !reset;
    assign src_valid  = data_valid && data_ready;
    assign src_data   = data_in;
    assign busy       = (state_q != S_IDLE);
`endif

    assign src_take = (state_q == S_IDLE) && src_valid;
    assign bit_done = (bit_cnt_q == CNT_LAST);
    assign tx       = tx_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (src_take) begin
                    word_d     = src_data;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes exactly on bit edges.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = word_d[bit_idx_d];
            S_PARITY: tx_d = (PAR_MODE == PAR_EVEN) ? ^word_d : ~^word_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: drives four frame formats (8E1, 8N1, 8O1, 7N2) at 104 clocks per bit
// and checks every serial bit against a scoreboard of expected line levels.
module tb_uart_tx_param;

    localparam int CPB         = 12_000_000 / 115_200;
    localparam int READY_LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [4];
    logic       dv  [4];
    logic       dr  [4];
    logic       txl [4];
    logic       bsy [4];

    logic [0:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.PARITY(2)) dut (
        .clock(clk), .reset(rst), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(dr[0]), .tx(txl[0]), .busy(bsy[0])
    );
    uart_tx_param #(.PARITY(0)) dut_8n1 (
        .clock(clk), .reset(rst), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(dr[1]), .tx(txl[1]), .busy(bsy[1])
    );
    uart_tx_param #(.PARITY(1)) dut_8o1 (
        .clock(clk), .reset(rst), .data_in(din[2]), .data_valid(dv[2]),
        .data_ready(dr[2]), .tx(txl[2]), .busy(bsy[2])
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .clock(clk), .reset(rst), .data_in(din[3][6:0]), .data_valid(dv[3]),
        .data_ready(dr[3]), .tx(txl[3]), .busy(bsy[3])
    );

    function automatic int cfg_bits(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        case (i)
            0:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_bits(input int i);
        return 1 + cfg_bits(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
    endfunction

    task automatic push_frame(input int i, input logic [7:0] w);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int b = 0; b < cfg_bits(i); b++) begin
            exp_q.push_back(w[b]);
            p = p ^ w[b];
        end
        if (cfg_par(i) == 2) exp_q.push_back(p);
        else if (cfg_par(i) == 1) exp_q.push_back(~p);
        for (int s = 0; s < cfg_stop(i); s++) exp_q.push_back(1'b1);
    endtask

    // Raises data_valid, waits for data_ready, returns just after the accepting edge.
    task automatic drive_accept(input int i, input logic [7:0] w, input string name);
        bit got;
        got = 1'b0;
        din[i] = w;
        dv[i]  = 1'b1;
        for (int n = 0; n < READY_LIMIT; n++) begin
            @(negedge clk);
            if (dr[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s accept: data_ready stayed %b for %0d clks, required 1", name, dr[i], READY_LIMIT);
            dv[i] = 1'b0;
            return;
        end
        push_frame(i, w);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int i, input int max_wait, input logic busy_after, input string name);
        bit         started;
        int         bad;
        logic [0:0] e;
        started = 1'b0;
        for (int n = 0; n < max_wait; n++) begin
            @(negedge clk);
            if (txl[i] === 1'b0) begin
                started = 1'b1;
                break;
            end
        end
        tests++;
        if (!started) begin
            fails++;
            $display("FAIL %s start: tx=%b after %0d clks, required 0", name, txl[i], max_wait);
            for (int b = 0; b < frame_bits(i) && exp_q.size() > 0; b++) void'(exp_q.pop_front());
            return;
        end
        for (int b = 0; b < frame_bits(i); b++) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s bit%0d: scoreboard empty, tx=%b", name, b, txl[i]);
                return;
            end
            e   = exp_q.pop_front();
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (txl[i] !== e[0] || bsy[i] !== 1'b1) bad++;
`ifndef UART_TX_FIFO_EN
                if (dr[i] !== 1'b0) bad++;
`endif
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL %s bit%0d: %0d bad clks, tx=%b busy=%b, required tx=%b busy=1 for %0d clks",
                         name, b, bad, txl[i], bsy[i], e, CPB);
            end
        end
        @(negedge clk);
        tests++;
        if (txl[i] !== 1'b1 || bsy[i] !== busy_after) begin
            fails++;
            $display("FAIL %s idle: tx=%b busy=%b, required tx=1 busy=%b", name, txl[i], bsy[i], busy_after);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (txl[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_tx[%0d]: got %b, required 1", i, txl[i]);
            end
            tests++;
            if (bsy[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy[%0d]: got %b, required 0", i, bsy[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (dr[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_ready[%0d]: got %b, required 1", i, dr[i]);
            end
        end
    endtask

    task automatic test_frames();
        int         tbl_i [5] = '{1, 0, 2, 0, 3};
        logic [7:0] tbl_w [5] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h7F};
        int         i;
        logic [7:0] w;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                i = tbl_i[k];
                w = tbl_w[k];
            end else begin
                i = $urandom_range(0, 3);
                w = 8'($urandom_range(0, 255));
            end
            drive_accept(i, w, "frame");
            dv[i] = 1'b0;
            check_frame(i, 1, 1'b0, "frame");
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_accept(0, 8'hA5, "mid_reset");
        dv[0] = 1'b0;
        exp_q.delete();
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        tests++;
        if (txl[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_bit3: tx=%b busy=%b, required tx=0 busy=1", txl[0], bsy[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort: tx=%b busy=%b, required tx=1 busy=0", txl[0], bsy[0]);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (dr[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_ready: got %b, required 1", dr[0]);
        end
        drive_accept(0, 8'h3C, "after_reset");
        dv[0] = 1'b0;
        check_frame(0, 1, 1'b0, "after_reset");
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        logic [7:0] words [17];
        for (int k = 0; k < 17; k++) words[k] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int k = 0; k < 17; k++) drive_accept(1, words[k], "fifo_push");
                tests++;
                if (dr[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL fifo_full_ready: got %b, required 0", dr[1]);
                end
                dv[1] = 1'b0;
            end
            begin
                for (int k = 0; k < 17; k++)
                    check_frame(1, (k == 0) ? 3 : 1, (k == 16) ? 1'b0 : 1'b1, "fifo_frame");
            end
        join
    endtask
`else
    task automatic test_back_to_back();
        drive_accept(1, 8'h5A, "b2b_first");
        din[1] = 8'hC3;
        push_frame(1, 8'hC3);
        #1;
        tests++;
        if (dr[1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready: got %b, required 0", dr[1]);
        end
        check_frame(1, 1, 1'b0, "b2b_first");
        @(posedge clk);
        #1;
        dv[1] = 1'b0;
        check_frame(1, 1, 1'b0, "b2b_second");
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            dv[i]  = 1'b0;
        end
        test_reset();
        test_frames();
        test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`else
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached after %0d tests, required completion", tests);
        $fatal(1, "watchdog");
    end

endmodule
